// File: rtl/puf_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// puf_ctrl_pkg
// Shared definitions for the PUF request scheduler:
//   - sched_state_t : scheduler FSM states (IDLE, LOAD, RUN, RESP)
//   - CHAL_W        : PUF challenge width
//   - RESP_W        : PUF response width
//   - LOAD_CYC      : number of cycles the PUF core is held in reset in LOAD
// -----------------------------------------------------------------------------
package puf_ctrl_pkg;

   localparam int CHAL_W   = 16;
   localparam int RESP_W   = 128;
   localparam int LOAD_CYC = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_RESP = 2'd3
   } sched_state_t;

endpackage

// File: rtl/puf_rr_arbiter.sv
// -----------------------------------------------------------------------------
// puf_rr_arbiter
// Combinational round-robin selector. The requester at i_ptr has the highest
// priority, then i_ptr+1, ... wrapping around modulo NUM_REQ.
// Ports:
//   i_req   [NUM_REQ-1:0] : request levels
//   i_ptr   [IDX_W-1:0]   : index holding highest priority
//   o_gnt   [NUM_REQ-1:0] : one-hot winner (all zero when no request)
//   o_idx   [IDX_W-1:0]   : binary index of the winner
//   o_valid               : at least one request present
// -----------------------------------------------------------------------------
module puf_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_valid
);

   // Distance of each position from the pointer, measured upward with wrap.
   // The pending request with the smallest distance wins.
   logic [IDX_W:0] w_dist [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_dist
         localparam logic [IDX_W:0] POS = (IDX_W + 1)'(gi);
         assign w_dist[gi] = (POS >= {1'b0, i_ptr}) ?
                             (POS - {1'b0, i_ptr}) :
                             (POS + (IDX_W + 1)'(NUM_REQ) - {1'b0, i_ptr});
      end
   endgenerate

   always_comb begin
      logic [IDX_W:0] best;
      best    = '1;
      o_idx   = '0;
      o_valid = |i_req;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i_req[i] && (w_dist[i] < best)) begin
            best  = w_dist[i];
            o_idx = IDX_W'(i);
         end
      end
      o_gnt = o_valid ? (NUM_REQ'(1) << o_idx) : '0;
   end

endmodule

// File: rtl/puf_req_sched.sv
// -----------------------------------------------------------------------------
// puf_req_sched
// Shares one 128-bit PUF core among NUM_REQ requesters. A round-robin winner
// is granted in IDLE, its challenge is latched, the core is held in reset for
// two LOAD cycles, released in RUN until puf_done, and the captured response is
// offered on a valid/ready interface in RESP.
//
// Optional feature macro: PUF_SCHED_TIMEOUT_EN
//   defined   -> RUN aborts after TIMEOUT_CYC cycles without puf_done, issuing
//                a response with rsp_err=1 and rsp_data=0
//   undefined -> RUN waits indefinitely, rsp_err is constant 0
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   req, req_chal       : request levels and packed per-requester challenges
//   gnt                 : one-cycle one-hot grant pulse
//   rsp_valid/ready     : response handshake
//   rsp_id/data/err     : served requester, captured response, timeout flag
//   puf_rst, puf_c      : PUF core reset and challenge
//   puf_done, puf_out   : PUF core completion flag and result
//   busy                : scheduler not in IDLE
// -----------------------------------------------------------------------------
module puf_req_sched
   import puf_ctrl_pkg::*;
#(
   parameter  int NUM_REQ     = 4,
   parameter  int TIMEOUT_CYC = 255,
   localparam int IDX_W       = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*CHAL_W-1:0] req_chal,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [IDX_W-1:0]          rsp_id,
   output logic [RESP_W-1:0]         rsp_data,
   output logic                      rsp_err,
   output logic                      puf_rst,
   output logic [CHAL_W-1:0]         puf_c,
   input  logic                      puf_done,
   input  logic [RESP_W-1:0]         puf_out,
   output logic                      busy
);

   generate
      if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
         $error("puf_req_sched: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
      end
   endgenerate

   sched_state_t       r_state;
   sched_state_t       w_state_next;
   logic [1:0]         r_load_cnt;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_id;
   logic [CHAL_W-1:0]  r_chal;
   logic [RESP_W-1:0]  r_data;

   logic [NUM_REQ-1:0] w_arb_gnt;
   logic [IDX_W-1:0]   w_arb_idx;
   logic               w_arb_valid;
   logic [CHAL_W-1:0]  w_sel_chal;
   logic [CHAL_W-1:0]  w_chal_arr [NUM_REQ];

   logic               w_take;     // grant accepted this cycle
   logic               w_done_ok;  // core finished in RUN
   logic               w_tmo;      // RUN aborted by timeout
   logic               w_hs;       // response handshake
   logic               w_tmo_hit;
   logic               w_err;

   puf_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_gnt   (w_arb_gnt),
      .o_idx   (w_arb_idx),
      .o_valid (w_arb_valid)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_chal
         assign w_chal_arr[gi] = req_chal[gi*CHAL_W +: CHAL_W];
      end
   endgenerate

   always_comb begin
      w_sel_chal = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_arb_gnt[i]) begin
            w_sel_chal = w_chal_arr[i];
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_take       = 1'b0;
      w_done_ok    = 1'b0;
      w_tmo        = 1'b0;
      w_hs         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_arb_valid) begin
               w_take       = 1'b1;
               w_state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (r_load_cnt == 2'(LOAD_CYC - 1)) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            // Completion wins over a timeout landing on the same cycle.
            if (puf_done) begin
               w_done_ok    = 1'b1;
               w_state_next = ST_RESP;
            end else if (w_tmo_hit) begin
               w_tmo        = 1'b1;
               w_state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_hs         = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // LOAD cycle counter, cleared whenever the FSM is elsewhere.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_load_cnt <= '0;
      end else if (r_state == ST_LOAD) begin
         r_load_cnt <= r_load_cnt + 2'd1;
      end else begin
         r_load_cnt <= '0;
      end
   end

   // ---------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_chal <= '0;
         r_id   <= '0;
         r_data <= '0;
         r_ptr  <= '0;
      end else begin
         if (w_take) begin
            r_chal <= w_sel_chal;
            r_id   <= w_arb_idx;
         end
         if (w_done_ok) begin
            r_data <= puf_out;
         end else if (w_tmo) begin
            r_data <= '0;
         end
         if (w_hs) begin
            r_ptr <= (r_id == IDX_W'(NUM_REQ - 1)) ? '0 : (r_id + IDX_W'(1));
         end
      end
   end

`ifdef PUF_SCHED_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_err;

   // r_tmo_cnt holds (RUN cycle number - 1); the limit is hit on the
   // TIMEOUT_CYC-th RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo_cnt <= '0;
         r_err     <= 1'b0;
      end else begin
         if (r_state == ST_RUN) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
         end else begin
            r_tmo_cnt <= '0;
         end
         if (w_done_ok) begin
            r_err <= 1'b0;
         end else if (w_tmo) begin
            r_err <= 1'b1;
         end
      end
   end

   assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
   assign w_err     = r_err;
`else
   assign w_tmo_hit = 1'b0;
   assign w_err     = 1'b0;
`endif

   // ----------------------------------------------------------- outputs
   // gnt is masked by rst so that no grant is visible while reset is held.
   assign gnt       = ((r_state == ST_IDLE) && !rst) ? w_arb_gnt : '0;
   assign rsp_valid = (r_state == ST_RESP);
   assign busy      = (r_state != ST_IDLE);
   assign rsp_id    = r_id;
   assign rsp_data  = r_data;
   assign rsp_err   = w_err;
   assign puf_c     = r_chal;
   // Core runs in RUN and stays released in a normal RESP so its output is
   // undisturbed; an aborted (timeout) response keeps the core in reset.
   assign puf_rst   = !((r_state == ST_RUN) || ((r_state == ST_RESP) && !w_err));

endmodule

// File: tb/tb_puf_req_sched.sv
// -----------------------------------------------------------------------------
// tb_puf_req_sched
// Transaction-level bench for puf_req_sched (NUM_REQ=4, TIMEOUT_CYC=20).
// A behavioural PUF core answers after a programmed number of RUN cycles with
// a fixed function of the challenge it sees; expected responses are computed
// from the challenge the requester offered.
// -----------------------------------------------------------------------------
module tb_puf_req_sched;

   localparam int NR  = 4;
   localparam int TMO = 20;

   logic          clk;
   logic          rst;
   logic [NR-1:0] req;
   logic [NR*16-1:0] req_chal;
   logic [NR-1:0] gnt;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_id;
   logic [127:0]  rsp_data;
   logic          rsp_err;
   logic          puf_rst;
   logic [15:0]   puf_c;
   logic          puf_done;
   logic [127:0]  puf_out;
   logic          busy;

   puf_req_sched #(
      .NUM_REQ     (NR),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_chal  (req_chal),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .puf_rst   (puf_rst),
      .puf_c     (puf_c),
      .puf_done  (puf_done),
      .puf_out   (puf_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int m_ptr  = 0;   // expected round-robin pointer
   int puf_n  = 0;   // RUN cycle on which the core model finishes (0 = never)
   int puf_cnt = 0;

   function automatic logic [127:0] puf_fn(input logic [15:0] c);
      return {c, ~c, c ^ 16'h3C3C, c + 16'h0101, {c[7:0], c[15:8]},
              c ^ 16'hA5A5, c - 16'h0007, c ^ 16'hD00D};
   endfunction

   // Behavioural PUF core: counts cycles out of reset, raises puf_done on the
   // programmed cycle; the output is wrong whenever puf_done is low.
   always @(negedge clk) begin
      if (puf_rst) begin
         puf_cnt  = 0;
         puf_done = 1'b0;
      end else begin
         puf_cnt++;
         puf_done = (puf_n != 0) && (puf_cnt == puf_n);
      end
      puf_out = puf_done ? puf_fn(puf_c) : ~puf_fn(puf_c);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Round-robin reference: first requester at or above ptr, with wrap.
   function automatic int rr_pick(input int ptr, input logic [NR-1:0] r);
      for (int k = 0; k < NR; k++) begin
         if (r[(ptr + k) % NR]) return (ptr + k) % NR;
      end
      return 0;
   endfunction

   // One complete transaction, starting in an IDLE cycle (#1 after posedge).
   task automatic do_txn(input logic [NR-1:0] reqv, input logic [NR*16-1:0] chalv,
                         input bit hold, input bit tweak, input int n_done,
                         input int wait_cyc, input int exp_id, input bit exp_err);
      logic [15:0]  exp_chal;
      logic [127:0] exp_data;
      int           exp_lat;
      int           lat;
      bit           quiet;
      bit           stable;
      exp_chal  = chalv[exp_id*16 +: 16];
      exp_data  = exp_err ? 128'd0 : puf_fn(exp_chal);
      exp_lat   = 3 + (exp_err ? TMO : n_done);
      puf_n     = exp_err ? 0 : n_done;
      req       = reqv;
      req_chal  = chalv;
      rsp_ready = 1'b0;
      #1;
      chk("gnt", gnt, 128'(1) << exp_id);
      chk("idle_flags", {puf_rst, busy}, 2'b10);
      tick();
      if (!hold) req = '0;
      if (tweak) req_chal = '1;
      chk("puf_c_load", puf_c, exp_chal);
      quiet = 1'b1;
      lat   = 1;
      while (rsp_valid !== 1'b1 && lat < 300) begin
         if (gnt !== '0 || puf_c !== exp_chal) quiet = 1'b0;
         tick();
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("inflight_quiet", quiet, 1'b1);
      chk("rsp_id", rsp_id, exp_id);
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_err", rsp_err, exp_err);
      if (exp_err) chk("tmo_puf_rst", puf_rst, 1'b1);
      stable = 1'b1;
      for (int w = 0; w < wait_cyc; w++) begin
         tick();
         if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_id !== 2'(exp_id) ||
             gnt !== '0 || puf_c !== exp_chal) stable = 1'b0;
      end
      if (wait_cyc > 0) chk("resp_hold", stable, 1'b1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("valid_drop", rsp_valid, 1'b0);
      m_ptr = (exp_id + 1) % NR;
      $display("TXN req=%b id=%0d lat=%0d err=%0d data=%h", reqv, rsp_id, lat, rsp_err, rsp_data);
   endtask

   typedef struct {
      logic [NR-1:0] reqv;
      bit            hold;
      bit            tweak;
      int            n_done;
      int            wait_cyc;
      int            exp_id;
   } vec_t;

   vec_t vecs[12];
   localparam logic [NR*16-1:0] CHAL_BASE = {16'hBEEF, 16'h00A5, 16'h1234, 16'hC0DE};

   initial begin
      logic [NR*16-1:0] rchal;
      logic [NR-1:0]    rreq;
      int               rid;

      //         reqv     hold tweak n  wait id
      vecs[0]  = '{4'b1111, 1, 0,  4,  0, 0};
      vecs[1]  = '{4'b1111, 1, 0,  4,  0, 1};
      vecs[2]  = '{4'b1111, 1, 0,  4,  0, 2};
      vecs[3]  = '{4'b1111, 1, 0,  4,  0, 3};
      vecs[4]  = '{4'b1111, 1, 0,  4,  0, 0};
      vecs[5]  = '{4'b0010, 0, 0, 40,  0, 1};
      vecs[6]  = '{4'b1001, 1, 0,  6, 10, 3};
      vecs[7]  = '{4'b0001, 0, 0,  3,  0, 0};
      vecs[8]  = '{4'b0100, 0, 1,  7,  2, 2};
      vecs[9]  = '{4'b0001, 0, 0,  1,  0, 0};
      vecs[10] = '{4'b0011, 0, 0,  2,  0, 1};
      vecs[11] = '{4'b0011, 0, 0,  5,  0, 0};

      rst       = 1'b1;
      req       = '1;
      req_chal  = CHAL_BASE;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_id", rsp_id, 2'd0);
      chk("rst_rsp_data", rsp_data, 128'd0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_puf_rst", puf_rst, 1'b1);
      chk("rst_puf_c", puf_c, 16'h0000);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      req = '0;
      tick();

      for (int v = 0; v < 12; v++) begin
         do_txn(vecs[v].reqv, CHAL_BASE, vecs[v].hold, vecs[v].tweak,
                vecs[v].n_done, vecs[v].wait_cyc, vecs[v].exp_id, 1'b0);
      end

      // Reset during RUN after the pointer has moved away from 0.
      do_txn(4'b0001, CHAL_BASE, 0, 0, 2, 0, rr_pick(m_ptr, 4'b0001), 1'b0);
      req      = 4'b0101;
      req_chal = CHAL_BASE;
      puf_n    = 50;
      #1;
      chk("pre_rst_gnt", gnt, 4'b0100);
      repeat (5) tick();
      chk("run_puf_rst", puf_rst, 1'b0);
      rst = 1'b1;
      #1;
      chk("async_puf_rst", puf_rst, 1'b1);
      chk("async_rsp_valid", rsp_valid, 1'b0);
      chk("async_busy", busy, 1'b0);
      chk("async_gnt", gnt, 4'b0000);
      tick();
      rst   = 1'b0;
      m_ptr = 0;
      do_txn(4'b0101, CHAL_BASE, 0, 0, 5, 0, 0, 1'b0);

`ifdef PUF_SCHED_TIMEOUT_EN
      do_txn(4'b1000, CHAL_BASE, 0, 0, 0, 2, rr_pick(m_ptr, 4'b1000), 1'b1);
      do_txn(4'b0010, CHAL_BASE, 0, 0, 4, 0, rr_pick(m_ptr, 4'b0010), 1'b0);
`endif

      // Randomised transactions against the round-robin reference.
      for (int n = 0; n < 30; n++) begin
         rreq  = NR'($urandom_range(1, (1 << NR) - 1));
         rchal = {$urandom, $urandom};
         rid   = rr_pick(m_ptr, rreq);
         do_txn(rreq, rchal, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                $urandom_range(1, 12), $urandom_range(0, 3), rid, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/puf_req_sched.md
PUF_REQ_SCHED -- requirements
Module: puf_req_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 255, RUN-state cycle limit before abort (only used with the Configuration macro).
REQ-003 Port clk, input, 1, single clock; all logic rising-edge.
REQ-004 Port rst, input, 1, reset, asynchronous, active-high.
REQ-005 Port req, input, NUM_REQ, per-requester request level.
REQ-006 Port req_chal, input, NUM_REQ*16, challenge of requester i at bits [16i+15:16i].
REQ-007 Port gnt, output, NUM_REQ, one-hot one-cycle grant pulse.
REQ-008 Port rsp_valid, output, 1, response available.
REQ-009 Port rsp_ready, input, 1, consumer accepts response.
REQ-010 Port rsp_id, output, clog2(NUM_REQ), index of served requester.
REQ-011 Port rsp_data, output, 128, captured PUF response.
REQ-012 Port rsp_err, output, 1, response aborted by timeout.
REQ-013 Port puf_rst, output, 1, drives 128-bit PUF core synchronous reset.
REQ-014 Port puf_c, output, 16, challenge to PUF core.
REQ-015 Port puf_done, input, 1, PUF core completion flag.
REQ-016 Port puf_out, input, 128, PUF core result.
REQ-017 Port busy, output, 1, high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, RUN, RESP.
REQ-019 IDLE: puf_rst=1; if any req bit high, one-cycle gnt to round-robin winner, latch its challenge into puf_c and index into rsp_id, go LOAD next cycle.
REQ-020 Round-robin: highest priority at ptr, searching upward with wrap; ptr resets to 0 and becomes winner+1 (mod NUM_REQ) on RESP handshake.
REQ-021 LOAD: puf_rst=1 for exactly 2 cycles, then RUN.
REQ-022 RUN: puf_rst=0; puf_done sampled only in RUN; on puf_done=1 latch puf_out into rsp_data, rsp_err=0, go RESP.
REQ-023 RESP: rsp_valid=1, rsp_data/rsp_id/rsp_err stable until rsp_valid&rsp_ready; that cycle -> IDLE, puf_rst=1 next cycle.
REQ-024 Grant-to-rsp_valid latency SHALL be 3 + N cycles, N = RUN cycles until puf_done.
REQ-025 Requester deasserting req or changing req_chal after gnt SHALL not affect the transaction in flight.
REQ-026 Requests arriving outside IDLE SHALL wait; no request is lost while held high.
REQ-027 Back-to-back: a request pending on the IDLE cycle after handshake SHALL be granted in that cycle.
REQ-028 puf_c SHALL hold the latched challenge from LOAD through RESP.

Reset
REQ-029 On rst: state IDLE, gnt=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, puf_rst=1, puf_c=0, busy=0, ptr=0, timeout counter=0.
REQ-030 rst asserted mid-transaction SHALL abort immediately with no response issued; after release the first grant uses ptr=0.

Configuration
REQ-031 Macro PUF_SCHED_TIMEOUT_EN: defined -> RUN counter; at TIMEOUT_CYC cycles without puf_done go RESP with rsp_err=1, rsp_data=0, puf_rst=1.
REQ-032 Without PUF_SCHED_TIMEOUT_EN: no counter, RUN waits indefinitely, rsp_err tied 0.

Structure
REQ-033 Package puf_ctrl_pkg SHALL hold state enum, CHAL_W=16, RESP_W=128.
REQ-034 Round-robin selection SHALL be sub-module puf_rr_arbiter (req, ptr in; one-hot grant, index out).

Verification
REQ-035 Single req[1], chal 16'h1234, puf_done after 40 RUN cycles, puf_out=X -> gnt=4'b0010, rsp_valid 43 cycles after gnt, rsp_id=1, rsp_data=X.
REQ-036 req=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0.
REQ-037 rsp_ready low 10 cycles in RESP -> rsp_valid/rsp_data stable all 10 cycles, no new gnt.
REQ-038 rst pulse during RUN -> puf_rst=1, rsp_valid=0, busy=0 same cycle (async); next grant to req[0] if pending.
REQ-039 With macro, TIMEOUT_CYC=20, puf_done never -> rsp_valid after 20 RUN cycles, rsp_err=1, rsp_data=0.
REQ-040 req[2] dropped cycle after gnt, chal changed to 16'hFFFF -> puf_c keeps original 16'h00A5, response still issued with rsp_id=2.
